// File: rtl/rv_commit_trace_fifo_if.sv
// Retirement-trace bundle: retire capture side, trace consumer side and status.
// Optional macro TRACE_STAMP_EN adds the trc_stamp_o field.
interface rv_commit_trace_fifo_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DCNT_W = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            clr_i;
    logic            ret_valid_i;
    logic [XLEN-1:0] ret_pc_i;
    logic [31:0]     ret_instr_i;
    logic            ret_rd_we_i;
    logic [4:0]      ret_rd_i;
    logic [XLEN-1:0] ret_rd_data_i;
    logic            ret_mem_we_i;
    logic [XLEN-1:0] ret_mem_addr_i;
    logic [XLEN-1:0] ret_mem_wdata_i;

    logic            trc_valid_o;
    logic            trc_ready_i;
    logic [XLEN-1:0] trc_pc_o;
    logic [31:0]     trc_instr_o;
    logic            trc_rd_we_o;
    logic [4:0]      trc_rd_o;
    logic [XLEN-1:0] trc_rd_data_o;
    logic            trc_mem_we_o;
    logic [XLEN-1:0] trc_mem_addr_o;
    logic [XLEN-1:0] trc_mem_wdata_o;
`ifdef TRACE_STAMP_EN
    logic [31:0]     trc_stamp_o;
`endif

    logic [CW-1:0]     count_o;
    logic              overflow_o;
    logic [DCNT_W-1:0] drop_cnt_o;

    // FIFO view
    modport slave (
        input  clr_i, ret_valid_i, ret_pc_i, ret_instr_i, ret_rd_we_i, ret_rd_i,
               ret_rd_data_i, ret_mem_we_i, ret_mem_addr_i, ret_mem_wdata_i, trc_ready_i,
        output trc_valid_o, trc_pc_o, trc_instr_o, trc_rd_we_o, trc_rd_o, trc_rd_data_o,
               trc_mem_we_o, trc_mem_addr_o, trc_mem_wdata_o, count_o, overflow_o, drop_cnt_o
`ifdef TRACE_STAMP_EN
        , output trc_stamp_o
`endif
    );

    // Core + monitor view
    modport master (
        output clr_i, ret_valid_i, ret_pc_i, ret_instr_i, ret_rd_we_i, ret_rd_i,
               ret_rd_data_i, ret_mem_we_i, ret_mem_addr_i, ret_mem_wdata_i, trc_ready_i,
        input  trc_valid_o, trc_pc_o, trc_instr_o, trc_rd_we_o, trc_rd_o, trc_rd_data_o,
               trc_mem_we_o, trc_mem_addr_o, trc_mem_wdata_o, count_o, overflow_o, drop_cnt_o
`ifdef TRACE_STAMP_EN
        , input trc_stamp_o
`endif
    );
endinterface

// File: rtl/rv_commit_trace_fifo.sv
// Retirement-trace FIFO: captures one normalised record per retired instruction,
// queues DEPTH of them and presents the head on a valid/ready port. The core is
// never stalled; a push into a full FIFO without a pop is dropped and counted.
// Optional macro TRACE_STAMP_EN stores a 32-bit retire-cycle stamp per record.
module rv_commit_trace_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DCNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    rv_commit_trace_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef TRACE_STAMP_EN
    localparam int unsigned SW = 32;
`else
    localparam int unsigned SW = 0;
`endif
    localparam int unsigned RW = 4 * XLEN + 39 + SW;

    logic [RW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic [DCNT_W-1:0] drop_cnt_q;

    logic          full, valid, pop, push, drop, rd_live, st_live;
    logic [RW-1:0] wr_rec, head;

`ifdef TRACE_STAMP_EN
    logic [31:0] cyc_q;

    // Free-running retire-cycle stamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cyc_q <= '0;
        else if (bus.clr_i) cyc_q <= '0;
        else                cyc_q <= cyc_q + 32'd1;
    end
`endif

    assign full    = (count_q == CW'(DEPTH));
    assign valid   = (count_q != '0);
    assign pop     = valid && bus.trc_ready_i;
    assign push    = bus.ret_valid_i && (!full || pop);
    assign drop    = bus.ret_valid_i && full && !pop;
    // x0 writes and non-stores carry no payload; zero it so monitors see canonical records
    assign rd_live = (bus.ret_rd_i != 5'd0);
    assign st_live = bus.ret_mem_we_i;

    assign wr_rec = {bus.ret_pc_i, bus.ret_instr_i,
                     bus.ret_rd_we_i && rd_live, bus.ret_rd_i,
                     rd_live ? bus.ret_rd_data_i : XLEN'(0),
                     st_live,
                     st_live ? bus.ret_mem_addr_i : XLEN'(0),
                     st_live ? bus.ret_mem_wdata_i : XLEN'(0)
`ifdef TRACE_STAMP_EN
                     , cyc_q
`endif
                    };

    // Head is forced to zero when empty so stale storage never leaks out
    assign head = valid ? mem[rd_ptr_q] : RW'(0);

    assign {bus.trc_pc_o, bus.trc_instr_o, bus.trc_rd_we_o, bus.trc_rd_o, bus.trc_rd_data_o,
            bus.trc_mem_we_o, bus.trc_mem_addr_o, bus.trc_mem_wdata_o
`ifdef TRACE_STAMP_EN
            , bus.trc_stamp_o
`endif
           } = head;

    assign bus.trc_valid_o = valid;
    assign bus.count_o     = count_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.drop_cnt_o  = drop_cnt_q;

    // Record storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_rec;
    end

    // Pointers, occupancy and overflow bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (bus.clr_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DCNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rv_commit_trace_fifo.sv
// Randomised and directed bench for rv_commit_trace_fifo against a queue model.
module tb_rv_commit_trace_fifo;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned DCNT_W = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        mem_we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] stamp;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_commit_trace_fifo_if #(.DEPTH(DEPTH), .XLEN(XLEN), .DCNT_W(DCNT_W)) bus ();

    rv_commit_trace_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .DCNT_W(DCNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rec_t q[$];
    bit   m_ovf;
    int   m_drops;
    logic [31:0] m_cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model
    task automatic compare();
        chk("count", 64'(bus.count_o), 64'(q.size()));
        chk("valid", 64'(bus.trc_valid_o), 64'(q.size() != 0));
        chk("overflow", 64'(bus.overflow_o), 64'(m_ovf));
        chk("drop_cnt", 64'(bus.drop_cnt_o), 64'(m_drops));
        if (q.size() != 0) begin
            chk("head_pc", 64'(bus.trc_pc_o), 64'(q[0].pc));
            chk("head_instr", 64'(bus.trc_instr_o), 64'(q[0].instr));
            chk("head_rd_we", 64'(bus.trc_rd_we_o), 64'(q[0].rd_we));
            chk("head_rd", 64'(bus.trc_rd_o), 64'(q[0].rd));
            chk("head_rd_data", 64'(bus.trc_rd_data_o), 64'(q[0].rd_data));
            chk("head_mem_we", 64'(bus.trc_mem_we_o), 64'(q[0].mem_we));
            chk("head_addr", 64'(bus.trc_mem_addr_o), 64'(q[0].addr));
            chk("head_wdata", 64'(bus.trc_mem_wdata_o), 64'(q[0].wdata));
`ifdef TRACE_STAMP_EN
            chk("head_stamp", 64'(bus.trc_stamp_o), 64'(q[0].stamp));
`endif
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                         input bit rd_we, input logic [4:0] rd, input logic [31:0] rd_data,
                         input bit mem_we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.ret_valid_i     = v;
        bus.ret_pc_i        = pc;
        bus.ret_instr_i     = instr;
        bus.ret_rd_we_i     = rd_we;
        bus.ret_rd_i        = rd;
        bus.ret_rd_data_i   = rd_data;
        bus.ret_mem_we_i    = mem_we;
        bus.ret_mem_addr_i  = addr;
        bus.ret_mem_wdata_i = wdata;
    endtask

    // Advance the model by the cycle's inputs, clock the DUT, compare at negedge
    task automatic step();
        bit   do_pop, do_push;
        rec_t r;
        do_pop  = (q.size() != 0) && bus.trc_ready_i;
        do_push = bus.ret_valid_i && (q.size() < DEPTH || do_pop);
        r.pc      = bus.ret_pc_i;
        r.instr   = bus.ret_instr_i;
        r.rd      = bus.ret_rd_i;
        r.rd_we   = (bus.ret_rd_i == 0) ? 1'b0 : bus.ret_rd_we_i;
        r.rd_data = (bus.ret_rd_i == 0) ? 32'd0 : bus.ret_rd_data_i;
        r.mem_we  = bus.ret_mem_we_i;
        r.addr    = bus.ret_mem_we_i ? bus.ret_mem_addr_i : 32'd0;
        r.wdata   = bus.ret_mem_we_i ? bus.ret_mem_wdata_i : 32'd0;
        r.stamp   = m_cyc;
        if (bus.clr_i) begin
            q.delete();
            m_ovf = 0; m_drops = 0; m_cyc = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
            else if (bus.ret_valid_i) begin
                m_ovf = 1;
                if (m_drops < (1 << DCNT_W) - 1) m_drops++;
            end
            m_cyc = m_cyc + 32'd1;
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_drops = 0; m_cyc = 0;
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 32'h1000 + 32'(i) * 4, 32'h00000013 + 32'(i), 1'b1, 5'(i + 1),
                  32'(i), 1'b0, 32'h0, 32'h0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        bus.clr_i = 1'b0;
        bus.trc_ready_i = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        model_reset();
        #12;
        compare();
        chk("rst_count_lit", 64'(bus.count_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single push, then pop
        drive(1'b1, 32'h4, 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0, '0, '0);
        step();
        chk("single_valid_lit", 64'(bus.trc_valid_o), 64'd1);
        chk("single_pc_lit", 64'(bus.trc_pc_o), 64'h4);
        chk("single_instr_lit", 64'(bus.trc_instr_o), 64'h00500093);
        chk("single_rd_data_lit", 64'(bus.trc_rd_data_o), 64'd5);
        chk("single_count_lit", 64'(bus.count_o), 64'd1);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        bus.trc_ready_i = 1'b1;
        step();
        chk("pop_valid_lit", 64'(bus.trc_valid_o), 64'd0);
        chk("pop_count_lit", 64'(bus.count_o), 64'd0);

        // Fill, overflow, hold stable, drain in order
        bus.trc_ready_i = 1'b0;
        push_idle(DEPTH);
        chk("fill_count_lit", 64'(bus.count_o), 64'd16);
        chk("fill_ovf_lit", 64'(bus.overflow_o), 64'd0);
        push_idle(1);
        chk("ovf_lit", 64'(bus.overflow_o), 64'd1);
        chk("drop_lit", 64'(bus.drop_cnt_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_pc_lit", 64'(bus.trc_pc_o), 64'h1000);
        end
        bus.trc_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        bus.trc_ready_i = 1'b0;

        // Clear pulse after creating some overflow
        push_idle(DEPTH + 2);
        bus.clr_i = 1'b1;
        step();
        bus.clr_i = 1'b0;
        chk("clr_count_lit", 64'(bus.count_o), 64'd0);
        chk("clr_ovf_lit", 64'(bus.overflow_o), 64'd0);
        chk("clr_drop_lit", 64'(bus.drop_cnt_o), 64'd0);

        // Full with simultaneous push and pop
        push_idle(DEPTH);
        bus.trc_ready_i = 1'b1;
        drive(1'b1, 32'hCAFE0000, 32'h00100073, 1'b0, 5'd3, 32'd0, 1'b1, 32'h80, 32'h55);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("pp_count_lit", 64'(bus.count_o), 64'd16);
        chk("pp_ovf_lit", 64'(bus.overflow_o), 64'd0);
        for (int i = 0; i < DEPTH - 1; i++) step();
        chk("pp_last_pc_lit", 64'(bus.trc_pc_o), 64'hCAFE0000);
        step();

        // Normalisation of x0 writes
        bus.trc_ready_i = 1'b0;
        drive(1'b1, 32'h8, 32'h00000013, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 32'h44, 32'h66);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("norm_rd_we_lit", 64'(bus.trc_rd_we_o), 64'd0);
        chk("norm_rd_data_lit", 64'(bus.trc_rd_data_o), 64'd0);
        chk("norm_addr_lit", 64'(bus.trc_mem_addr_o), 64'd0);

        // Randomised traffic with occasional clear and mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6, $urandom, $urandom, 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  1'($urandom), $urandom, $urandom);
            bus.trc_ready_i = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 7));
            bus.clr_i = ($urandom_range(0, 299) == 0);
            if (i % 1000 == 999) begin
                rst = 1'b1;
                #1;
                model_reset();
                compare();
                @(negedge clk);
                rst = 1'b0;
            end else begin
                step();
            end
        end
        bus.clr_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
